// File: rtl/buzz_sched.sv
// Round-robin alert buzzer scheduler: edge-captured requests, fixed-length tone then gap per grant.
// Optional macro BUZZ_PITCH_EN gives each channel its own buzzer pitch.
module buzz_sched #(
    parameter int unsigned NCH      = 10,
    parameter int unsigned TONE_CYC = 25000000,
    parameter int unsigned GAP_CYC  = 5000000,
    parameter int unsigned BASE_DIV = 25000,
    parameter int unsigned DIV_STEP = 2500
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           mute,
    output logic           buzzer_pin,
    output logic           busy,
    output logic [3:0]     cur_ch,
    output logic [NCH-1:0] pending
);

    localparam int unsigned CHW = 4;
    localparam int unsigned CW  = 32;

`ifdef BUZZ_PITCH_EN
    localparam bit PITCH_EN = 1'b1;
`else
    localparam bit PITCH_EN = 1'b0;
`endif
    localparam int unsigned STEP_EFF = PITCH_EN ? DIV_STEP : 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TONE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [NCH-1:0]   r_req_q;
    logic [NCH-1:0]   r_pending;
    logic [CHW-1:0]   r_cur_ch;
    logic [CW-1:0]    r_tone_cnt;
    logic [CW-1:0]    r_gap_cnt;
    logic [CW-1:0]    r_half_cnt;
    logic             r_phase;
    logic             r_pin;

    logic [NCH-1:0]   w_edge;
    logic [NCH-1:0]   w_clr;
    logic [CHW-1:0]   w_grant_idx;
    logic             w_any;
    logic [CW-1:0]    w_dist;
    logic [CW-1:0]    w_best;
    logic [CW-1:0]    w_half;
    logic             w_half_wrap;
    logic             w_grant;
    logic             w_tone_end;
    logic             w_phase_nxt;

    assign w_edge      = req & ~r_req_q;
    assign w_half      = CW'(BASE_DIV) + CW'(r_cur_ch) * CW'(STEP_EFF);
    assign w_half_wrap = (r_half_cnt == (w_half - CW'(1)));

    // Round-robin pick: smallest distance past the last granted channel wins.
    always_comb begin
        w_grant_idx = '0;
        w_any       = 1'b0;
        w_best      = CW'(NCH);
        w_dist      = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            w_dist = (CW'(i) + CW'(NCH) - CW'(1) - CW'(r_cur_ch)) % CW'(NCH);
            if (r_pending[i] && (w_dist < w_best)) begin
                w_best      = w_dist;
                w_grant_idx = CHW'(i);
                w_any       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_nxt = ST_TONE;
            ST_TONE: if (r_tone_cnt == '0) w_state_nxt = ST_GAP;
            ST_GAP:  if (r_gap_cnt == '0) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-state control strobes consumed by the datapath registers.
    always_comb begin
        w_grant     = 1'b0;
        w_tone_end  = 1'b0;
        w_clr       = '0;
        w_phase_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_grant = w_any;
                if (w_any) w_clr = {{(NCH-1){1'b0}}, 1'b1} << w_grant_idx;
            end
            ST_TONE: begin
                w_tone_end = (r_tone_cnt == '0);
                if (!w_tone_end) w_phase_nxt = w_half_wrap ? ~r_phase : r_phase;
            end
            default: ;
        endcase
    end

    // Set beats clear on the same bit, so a re-trigger during grant is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q    <= '0;
            r_pending  <= '0;
            r_cur_ch   <= CHW'(NCH - 1);
            r_tone_cnt <= '0;
            r_gap_cnt  <= '0;
            r_half_cnt <= '0;
            r_phase    <= 1'b0;
            r_pin      <= 1'b0;
        end else begin
            r_req_q   <= req;
            r_pending <= (r_pending & ~w_clr) | w_edge;
            r_phase   <= w_phase_nxt;
            r_pin     <= w_phase_nxt & ~mute;
            if (w_grant) begin
                r_cur_ch   <= w_grant_idx;
                r_tone_cnt <= CW'(TONE_CYC - 1);
                r_half_cnt <= '0;
            end else if (w_tone_end) begin
                r_gap_cnt  <= CW'(GAP_CYC - 1);
                r_half_cnt <= '0;
            end else if (r_state == ST_TONE) begin
                r_tone_cnt <= r_tone_cnt - CW'(1);
                r_half_cnt <= w_half_wrap ? '0 : r_half_cnt + CW'(1);
            end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt  <= r_gap_cnt - CW'(1);
            end
        end
    end

    assign buzzer_pin = r_pin;
    assign busy       = (r_state != ST_IDLE);
    assign cur_ch     = r_cur_ch;
    assign pending    = r_pending;

endmodule

// File: tb/tb_buzz_sched.sv
// Scoreboard bench for buzz_sched: expected grants queued by stimulus, checked by a negedge monitor.
module tb_buzz_sched;

    localparam int NCH  = 10;
    localparam int TONE = 20;
    localparam int GAP  = 4;
    localparam int BASE = 2;
    localparam int STEP = 1;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] req;
    logic           mute;
    logic           buzzer_pin;
    logic           busy;
    logic [3:0]     cur_ch;
    logic [NCH-1:0] pending;

    buzz_sched #(
        .NCH(NCH), .TONE_CYC(TONE), .GAP_CYC(GAP), .BASE_DIV(BASE), .DIV_STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .mute(mute),
        .buzzer_pin(buzzer_pin), .busy(busy), .cur_ch(cur_ch), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int busy_cyc;
        int rises;
        int first;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   idle_pin_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int half_of(input int ch);
`ifdef BUZZ_PITCH_EN
        return BASE + ch * STEP;
`else
        return BASE + 0 * ch;
`endif
    endfunction

    // Pin toggles at multiples of the half period; a toggle landing on the tone's last edge is lost to the GAP clear.
    function automatic exp_t mk(input int ch, input bit muted);
        exp_t e;
        int h;
        h = half_of(ch);
        e.ch = ch;
        e.busy_cyc = TONE + GAP;
        e.rises = 0;
        e.first = 0;
        if (!muted) begin
            for (int k = 1; k * h <= TONE - 1; k++) begin
                if (k % 2 == 1) e.rises++;
                if (k == 1) e.first = h + 1;
            end
        end
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(input string name);
        int n;
        n = 0;
        while ((busy || pending != '0) && n < 400) begin
            tick(1);
            n++;
        end
        chk({name, "_timeout"}, int'(busy || pending != '0), 0);
    endtask

    // Monitor: one scoreboard entry per busy period.
    int   m_bc, m_rises, m_first;
    bit   m_active = 1'b0, m_abort = 1'b0, m_prev_busy = 1'b0, m_prev_pin = 1'b0;
    exp_t m_cur;

    always @(negedge clk) begin
        if (rst && m_active) m_abort = 1'b1;
        if (busy && !m_prev_busy) begin
            chk("grant_expected", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                m_cur    = q.pop_front();
                m_active = 1'b1;
                m_abort  = 1'b0;
                m_bc     = 1;
                m_rises  = 0;
                m_first  = 0;
                chk("grant_ch", int'(cur_ch), m_cur.ch);
            end
        end else if (busy) begin
            m_bc++;
        end
        if (m_active && busy && buzzer_pin && !m_prev_pin) begin
            m_rises++;
            if (m_first == 0) m_first = m_bc;
        end
        if (!busy && m_prev_busy && m_active) begin
            if (!m_abort) begin
                chk("busy_cycles", m_bc, m_cur.busy_cyc);
                chk("pin_rises", m_rises, m_cur.rises);
                chk("first_rise", m_first, m_cur.first);
            end
            m_active = 1'b0;
        end
        if (!busy && buzzer_pin) idle_pin_err++;
        m_prev_busy = busy;
        m_prev_pin  = buzzer_pin;
    end

    initial begin
        int busy_seen;
        rst  = 1'b1;
        req  = '0;
        mute = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pending", int'(pending), 0);
        chk("reset_pin", int'(buzzer_pin), 0);
        chk("reset_cur_ch", int'(cur_ch), 9);

        // Single pulse on channel 3
        req = 10'h008;
        q.push_back(mk(3, 1'b0));
        tick(1);
        req = '0;
        chk("s1_pending", int'(pending), 'h008);
        chk("s1_busy_pre", int'(busy), 0);
        tick(1);
        chk("s1_busy", int'(busy), 1);
        chk("s1_cur_ch", int'(cur_ch), 3);
        chk("s1_clr", int'(pending), 0);
        wait_quiet("s1");

        // Serve channel 5, then 2/5/8 together must wrap: 8, 2, 5
        req = 10'h020;
        q.push_back(mk(5, 1'b0));
        tick(1);
        req = '0;
        wait_quiet("s2a");
        chk("s2_cur5", int'(cur_ch), 5);
        req = 10'h124;
        q.push_back(mk(8, 1'b0));
        q.push_back(mk(2, 1'b0));
        q.push_back(mk(5, 1'b0));
        tick(1);
        chk("s2_pending", int'(pending), 'h124);
        tick(1);
        chk("s2_first_ch", int'(cur_ch), 8);
        chk("s2_pending_after", int'(pending), 'h024);
        req = '0;
        wait_quiet("s2b");

        // Three channel-4 pulses during channel 7's tone collapse into one
        req = 10'h080;
        q.push_back(mk(7, 1'b0));
        q.push_back(mk(4, 1'b0));
        tick(1);
        req = '0;
        tick(2);
        repeat (3) begin
            req = 10'h010;
            tick(1);
            req = '0;
            tick(1);
        end
        chk("s3_pending", int'(pending), 'h010);
        chk("s3_busy", int'(busy), 1);
        chk("s3_cur_ch", int'(cur_ch), 7);
        wait_quiet("s3");

        // Muted channel 1
        mute = 1'b1;
        req  = 10'h002;
        q.push_back(mk(1, 1'b1));
        tick(1);
        req = '0;
        tick(1);
        chk("s4_busy", int'(busy), 1);
        chk("s4_cur_ch", int'(cur_ch), 1);
        chk("s4_pending", int'(pending), 0);
        wait_quiet("s4");
        mute = 1'b0;

        // Reset during channel 6's tone with channels 0 and 2 pending
        req = 10'h040;
        q.push_back(mk(6, 1'b0));
        tick(1);
        req = '0;
        tick(1);
        req = 10'h005;
        tick(1);
        req = '0;
        chk("s5_pending", int'(pending), 'h005);
        chk("s5_busy", int'(busy), 1);
        tick(8);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("s5_busy", int'(busy), 0);
        chk("s5_pending", int'(pending), 0);
        chk("s5_pin", int'(buzzer_pin), 0);
        chk("s5_cur_ch", int'(cur_ch), 9);
        busy_seen = 0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (busy) busy_seen++;
        end
        chk("s5_no_tone", busy_seen, 0);

        chk("queue_empty", q.size(), 0);
        chk("idle_pin", idle_pin_err, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/buzz_sched.md
BUZZ_SCHED -- requirements
Module: buzz_sched

Interface
REQ-001 Parameter NCH, default 10: number of alert channels, one per 4-bit status counter.
REQ-002 Parameter TONE_CYC, default 25000000: clk cycles that one granted tone lasts.
REQ-003 Parameter GAP_CYC, default 5000000: silent clk cycles after each tone.
REQ-004 Parameter BASE_DIV, default 25000: buzzer half-period in clk cycles for channel 0.
REQ-005 Parameter DIV_STEP, default 2500: half-period increment per channel index.
REQ-006 clk  input  1: single system clock; all logic on its rising edge.
REQ-007 rst  input  1: synchronous, active-high reset.
REQ-008 req  input  NCH: per-channel alert level (counter wrapped); only rising edges count.
REQ-009 mute  input  1: forces buzzer_pin low; sequencing is unaffected.
REQ-010 buzzer_pin  output  1: registered square-wave drive to the single shared buzzer.
REQ-011 busy  output  1: high when the state is not IDLE.
REQ-012 cur_ch  output  4: index of the channel granted most recently.
REQ-013 pending  output  NCH: registered sticky flags of alerts not yet served.

Function
REQ-014 req is registered into req_q every cycle; edge = req & ~req_q.
REQ-015 pending <= (pending & ~clr) | edge; on a simultaneous set and clear of the same bit, set wins and the bit stays 1.
REQ-016 States: IDLE, TONE, GAP; IDLE -> TONE -> GAP -> IDLE, with no other transitions except reset.
REQ-017 In IDLE with pending != 0, grant the first set bit searching cur_ch+1, cur_ch+2, ... modulo NCH (round-robin); the search wraps from NCH-1 to 0.
REQ-018 On grant: cur_ch <= granted index; clr asserts that bit the same cycle; tone counter loads TONE_CYC-1; half-period counter clears; state <= TONE.
REQ-019 Latency: req rises before edge k -> pending bit visible after edge k -> state TONE after edge k+1 (with IDLE and no other pending bits).
REQ-020 Stay in IDLE when pending == 0; busy=0, buzzer_pin=0.
REQ-021 In TONE, buzzer_pin toggles each time the half-period counter reaches HALF-1; the counter then restarts from 0.
REQ-022 HALF = BASE_DIV + cur_ch*DIV_STEP, computed at least 32 bits wide with no truncation.
REQ-023 After exactly TONE_CYC cycles in TONE: state <= GAP, buzzer_pin <= 0, gap counter loads GAP_CYC-1.
REQ-024 After exactly GAP_CYC cycles in GAP: state <= IDLE; arbitration resumes the next cycle.
REQ-025 An edge on the channel currently sounding re-sets its pending bit; that channel is served again only after round-robin reaches it.
REQ-026 Multiple edges of one channel before service collapse into one tone.
REQ-027 buzzer_pin = 0 whenever mute = 1 or state != TONE.

Reset
REQ-028 rst=1 at a clk edge: state <= IDLE, pending <= 0, req_q <= 0, all counters <= 0, cur_ch <= NCH-1 (first grant searches from channel 0), buzzer_pin <= 0.
REQ-029 Reset asserted mid-TONE or mid-GAP aborts immediately; edges present during reset are discarded.

Configuration
REQ-030 Macro BUZZ_PITCH_EN defined: HALF per REQ-022, giving a distinct pitch per channel.
REQ-031 Macro BUZZ_PITCH_EN undefined: HALF = BASE_DIV for all channels; DIV_STEP is ignored; all other behaviour is identical.

Verification
Bench parameters: NCH=10, TONE_CYC=20, GAP_CYC=4, BASE_DIV=2, DIV_STEP=1.
REQ-032 Apply rst for 2 cycles, then idle -> busy=0, pending=0, buzzer_pin=0, cur_ch=9.
REQ-033 Pulse req[3] for 1 cycle -> pending[3]=1 one cycle later; TONE the next cycle with cur_ch=3; pin toggles every 5 cycles (PITCH_EN); GAP after 20 cycles; IDLE after 4 more.
REQ-034 Raise req[2], req[5] and req[8] together after cur_ch=5 is served -> service order 8, 2, 5 (wrap-around); each tone is 20 cycles plus a 4-cycle gap.
REQ-035 Pulse req[4] three times during another channel's TONE -> pending[4]=1 only once; exactly one tone for channel 4.
REQ-036 Hold mute=1 during a channel-1 request -> buzzer_pin stays 0; busy timing and pending clearing are unchanged.
REQ-037 Assert rst at cycle 10 of TONE with pending=0x005 -> after reset: IDLE, pending=0, pin=0; no tone follows.
